dcache_ctrl: RTL and testbench

- Parametrised direct-mapped, write-back, write-allocate data cache.
- Sits between the core's MEM stage (ALU-result address, rs2 store data, 4-bit byte write enables) and a slower word-wide data memory.
- Replaces the fixed single-cycle data SRAM path:
  - stalls the pipeline on a miss;
  - bursts whole lines to and from memory with a per-beat request/ack handshake;
  - supports an explicit flush of dirty lines.

---
 rtl/dcache_ctrl.sv | 168 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and a word-wide memory.
// Misses and flushes move whole lines as WORDS-beat req/ack bursts while the core is stalled.
module dcache_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINES  = 16,
  parameter int unsigned WORDS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [DATA_W/8-1:0]   cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam int unsigned WSEL_W = $clog2(WORDS);
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - WSEL_W - IDX_W;

  localparam logic [OFF_W-1:0]  OFF_ZERO  = '0;
  localparam logic [WSEL_W-1:0] BEAT_LAST = WSEL_W'(WORDS - 1);
  localparam logic [IDX_W-1:0]  LINE_LAST = IDX_W'(LINES - 1);

  typedef enum logic [2:0] {IDLE, WB, REFILL, FLUSH_SCAN, FLUSH_WB} state_t;
  state_t state, state_nx;

  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES*WORDS];

  logic [WSEL_W-1:0] beat;
  logic [IDX_W-1:0]  line_ptr;

  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  cpu_idx;
  logic [WSEL_W-1:0] cpu_wsel;
  logic              unused_off;

  assign cpu_tag    = cpu_addr[ADDR_W-1 -: TAG_W];
  assign cpu_idx    = cpu_addr[OFF_W+WSEL_W +: IDX_W];
  assign cpu_wsel   = cpu_addr[OFF_W +: WSEL_W];
  assign unused_off = ^cpu_addr[OFF_W-1:0];

  logic             hit;
  logic             load_hit;
  logic             store_hit;
  logic             in_burst;
  logic             beat_ack;
  logic             last_ack;
  logic [IDX_W-1:0] wb_idx;

  assign hit       = cpu_req && valid[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);
  assign load_hit  = (state == IDLE) && hit && (cpu_we == '0);
  assign store_hit = (state == IDLE) && hit && (cpu_we != '0);
  // Derived from state rather than mem_req so the next-state logic has no loop through its own output
  assign in_burst  = (state == WB) || (state == REFILL) || (state == FLUSH_WB);
  assign beat_ack  = in_burst && mem_ack;
  assign last_ack  = beat_ack && (beat == BEAT_LAST);
  assign wb_idx    = (state == FLUSH_WB) ? line_ptr : cpu_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cpu_stall = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        cpu_stall = cpu_req && !hit;
        if (cpu_req && !hit)
          state_nx = (valid[cpu_idx] && dirty[cpu_idx]) ? WB : REFILL;
        else if (!cpu_req && flush_req)
          state_nx = FLUSH_SCAN;
      end
      WB, FLUSH_WB: begin
        cpu_stall = cpu_req;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_arr[wb_idx], wb_idx, beat, OFF_ZERO};
        mem_wdata = data_arr[{wb_idx, beat}];
        if (last_ack) begin
          if (state == WB)              state_nx = REFILL;
          else if (line_ptr == LINE_LAST) state_nx = IDLE;
          else                          state_nx = FLUSH_SCAN;
        end
      end
      REFILL: begin
        cpu_stall = cpu_req;
        mem_req   = 1'b1;
        mem_addr  = {cpu_tag, cpu_idx, beat, OFF_ZERO};
        if (last_ack) state_nx = IDLE;
      end
      FLUSH_SCAN: begin
        cpu_stall = cpu_req;
        if (valid[line_ptr] && dirty[line_ptr]) state_nx = FLUSH_WB;
        else if (line_ptr == LINE_LAST)         state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat       <= '0;
      line_ptr   <= '0;
      valid      <= '0;
      dirty      <= '0;
      cpu_rdata  <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      if (beat_ack) beat <= beat + WSEL_W'(1);
      if (load_hit) cpu_rdata <= data_arr[{cpu_idx, cpu_wsel}];
      if (store_hit) dirty[cpu_idx] <= 1'b1;
      case (state)
        IDLE: line_ptr <= '0;
        WB: if (last_ack) dirty[cpu_idx] <= 1'b0;
        REFILL: if (last_ack) begin
          valid[cpu_idx] <= 1'b1;
          dirty[cpu_idx] <= 1'b0;
        end
        FLUSH_SCAN: if (!(valid[line_ptr] && dirty[line_ptr])) begin
          if (line_ptr == LINE_LAST) flush_done <= 1'b1;
          else                       line_ptr   <= line_ptr + IDX_W'(1);
        end
        FLUSH_WB: if (last_ack) begin
          dirty[line_ptr] <= 1'b0;
          if (line_ptr == LINE_LAST) flush_done <= 1'b1;
          else                       line_ptr   <= line_ptr + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset: valid bits alone decide whether contents are meaningful
  always_ff @(posedge clk) begin
    if (store_hit) begin
      for (int unsigned b = 0; b < BYTES; b++)
        if (cpu_we[b]) data_arr[{cpu_idx, cpu_wsel}][8*b +: 8] <= cpu_wdata[8*b +: 8];
    end
    if ((state == REFILL) && beat_ack) begin
      data_arr[{cpu_idx, beat}] <= mem_rdata;
      if (beat == BEAT_LAST) tag_arr[cpu_idx] <= cpu_tag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a word memory model answers bursts, expected beats and load
// data are queued as stimulus is issued and popped as the cache produces them.
module tb_dcache_ctrl;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned NL = 16;
  localparam int unsigned NW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0;
  logic [3:0]    cpu_we = '0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          flush_req = 1'b0;
  logic          flush_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  dcache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LINES(NL), .WORDS(NW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .flush_req(flush_req), .flush_done(flush_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         exp_beats[$];
  logic [DW-1:0] exp_rd[$];
  int            n_vec = 0;
  int            n_err = 0;
  int unsigned   beats_seen = 0;
  int unsigned   ack_delay = 0;
  int unsigned   wait_cnt = 0;
  beat_t         hold;
  beat_t         cur;
  bit            mem_init = 1'b0;
  logic [DW-1:0] mem_model [16384];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] patt(input logic [AW-1:0] a);
    return 32'h1000_0000 | {16'h0, a};
  endfunction

  // Memory: acks each beat ack_delay cycles after it appears, checks it against the queue
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16384; i++) mem_model[i] = patt(AW'(i * 4));
      mem_model[4] = 32'hDEADBEEF;
      mem_init = 1'b1;
    end
    mem_ack = 1'b0;
    cur = {mem_we, mem_addr, mem_we ? mem_wdata : 32'h0};
    if (rst && mem_req) begin
      if (wait_cnt == 0) hold = cur;
      else chk("beat_hold", 64'(hold), 64'(cur));
      if (wait_cnt == ack_delay) begin
        mem_ack = 1'b1;
        if (mem_we) mem_model[mem_addr[15:2]] = mem_wdata;
        else        mem_rdata = mem_model[mem_addr[15:2]];
        beats_seen++;
        chk("beat_expected", 64'(exp_beats.size() != 0), 64'd1);
        if (exp_beats.size() != 0) chk("beat", 64'(cur), 64'(exp_beats.pop_front()));
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic push_reads(input logic [AW-1:0] base);
    for (int i = 0; i < 4; i++) exp_beats.push_back({1'b0, base + AW'(4 * i), 32'h0});
  endtask

  task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_beats.push_back({1'b1, a, d});
  endtask

  task automatic access(input string tag, input logic [AW-1:0] a, input logic [3:0] we,
                        input logic [DW-1:0] wd, input int exp_cyc);
    int cyc = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = a; cpu_we = we; cpu_wdata = wd;
    #1;
    while (cpu_stall && cyc < 400) begin
      @(negedge clk); #1; cyc++;
    end
    chk({tag, "_stall_cycles"}, 64'(cyc), 64'(exp_cyc));
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = '0;
    #1;
    if (we == 4'b0 && exp_rd.size() != 0) chk({tag, "_rdata"}, 64'(cpu_rdata), 64'(exp_rd.pop_front()));
    chk({tag, "_beats_left"}, 64'(exp_beats.size()), 64'd0);
  endtask

  task automatic do_flush(input string tag);
    int cyc = 0;
    @(negedge clk); flush_req = 1'b1;
    @(negedge clk); flush_req = 1'b0;
    #1;
    while (!flush_done && cyc < 400) begin
      @(negedge clk); #1; cyc++;
    end
    chk({tag, "_done_seen"}, 64'(flush_done), 64'd1);
    @(negedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(flush_done), 64'd0);
    chk({tag, "_beats_left"}, 64'(exp_beats.size()), 64'd0);
  endtask

  initial begin
    int unsigned n0;
    int cyc;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    chk("rst_rdata", 64'(cpu_rdata), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    @(negedge clk); rst = 1'b1;

    // Cold miss: 4 read beats, WORDS+1 stall samples
    push_reads(16'h0010);
    exp_rd.push_back(32'hDEADBEEF);
    access("load_0010", 16'h0010, 4'b0000, 32'h0, 5);

    // Store hit then load hit, no traffic
    n0 = beats_seen;
    access("store_0014", 16'h0014, 4'b0011, 32'h0000AAAA, 0);
    exp_rd.push_back(32'h1000AAAA);
    access("load_0014", 16'h0014, 4'b0000, 32'h0, 0);
    chk("hit_no_traffic", 64'(beats_seen - n0), 64'd0);

    // Dirty conflict miss with a slow memory
    ack_delay = 3;
    push_write(16'h0010, 32'hDEADBEEF);
    push_write(16'h0014, 32'h1000AAAA);
    push_write(16'h0018, 32'h10000018);
    push_write(16'h001C, 32'h1000001C);
    push_reads(16'h1010);
    exp_rd.push_back(32'h10001014);
    access("load_1014", 16'h1014, 4'b0000, 32'h0, 33);
    chk("mem_0014_written", 64'(mem_model[5]), 64'h1000AAAA);

    // Dirty lines at index 15 and 1, then flush
    ack_delay = 0;
    push_reads(16'h00F0);
    access("store_00f4", 16'h00F4, 4'b1111, 32'hCAFEF00D, 5);
    access("store_1010", 16'h1010, 4'b1100, 32'h55660000, 0);
    push_write(16'h1010, 32'h55661010);
    push_write(16'h1014, 32'h10001014);
    push_write(16'h1018, 32'h10001018);
    push_write(16'h101C, 32'h1000101C);
    push_write(16'h00F0, 32'h100000F0);
    push_write(16'h00F4, 32'hCAFEF00D);
    push_write(16'h00F8, 32'h100000F8);
    push_write(16'h00FC, 32'h100000FC);
    do_flush("flush1");
    chk("mem_00f4_flushed", 64'(mem_model[16'h00F4 >> 2]), 64'hCAFEF00D);

    n0 = beats_seen;
    exp_rd.push_back(32'hCAFEF00D);
    access("load_00f4_post", 16'h00F4, 4'b0000, 32'h0, 0);
    exp_rd.push_back(32'h55661010);
    access("load_1010_post", 16'h1010, 4'b0000, 32'h0, 0);
    chk("post_flush_no_traffic", 64'(beats_seen - n0), 64'd0);

    // Reset during the second refill beat
    ack_delay = 1;
    exp_beats.push_back({1'b0, 16'h2020, 32'h0});
    n0 = beats_seen;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 16'h2020; cpu_we = 4'b0000;
    cyc = 0;
    do begin
      @(negedge clk); #2; cyc++;
    end while (beats_seen == n0 && cyc < 100);
    chk("rst_first_beat", 64'(beats_seen - n0), 64'd1);
    @(negedge clk); #2;
    chk("rst_beat2_req", 64'(mem_req), 64'd1);
    chk("rst_beat2_addr", 64'(mem_addr), 64'h2024);
    rst = 1'b0;
    #1;
    chk("rst_mid_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mid_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mid_rdata", 64'(cpu_rdata), 64'd0);
    chk("rst_mid_beats_left", 64'(exp_beats.size()), 64'd0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // All lines invalid after reset: flush moves nothing
    ack_delay = 0;
    n0 = beats_seen;
    do_flush("flush_empty");
    chk("flush_empty_no_traffic", 64'(beats_seen - n0), 64'd0);

    push_reads(16'h2020);
    exp_rd.push_back(32'h10002020);
    access("reload_2020", 16'h2020, 4'b0000, 32'h0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
